// File: rtl/encoder8_to_3_seq_pkg.sv
// Shared widths, FSM state encoding and a one-hot helper for the sequential
// 8-to-3 priority encoder.
package encoder8_to_3_seq_pkg;

    localparam int unsigned REQ_W = 8;
    localparam int unsigned IDX_W = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    function automatic logic single_bit(input logic [REQ_W-1:0] v);
        return (v != '0) && ((v & (v - REQ_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational 8-input priority encoder; LOW_FIRST selects the lowest set
// index, otherwise the highest. An all-zero vector encodes to 0.
module prio_enc8
    import encoder8_to_3_seq_pkg::*;
#(
    parameter int unsigned LOW_FIRST = 1
) (
    input  logic [REQ_W-1:0] vec,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        idx = '0;
        // Later matches overwrite earlier ones, so the scan direction decides priority.
        for (int unsigned i = 0; i < REQ_W; i++) begin
            if (LOW_FIRST != 0) begin
                if (vec[REQ_W-1-i]) idx = IDX_W'(REQ_W-1-i);
            end else begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/encoder8_to_3_seq.sv
// Accepts an 8-bit request vector and emits the index of each set bit as a
// separate valid/ready beat; an all-zero vector yields a single zero beat.
module encoder8_to_3_seq
    import encoder8_to_3_seq_pkg::*;
#(
    parameter int unsigned LOW_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [REQ_W-1:0] in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out,
    output logic             last,
    output logic             zero
);

    logic [0:0]       state;
    logic [REQ_W-1:0] pending;
    logic             zero_q;
    logic [IDX_W-1:0] idx;
    logic             emitting;

    prio_enc8 #(.LOW_FIRST(LOW_FIRST)) u_prio (
        .vec (pending),
        .idx (idx)
    );

    assign emitting  = (state == EMIT);
    assign in_ready  = en && (state == IDLE);
    assign out_valid = en && emitting;
    assign out       = emitting ? idx : '0;
    assign zero      = emitting && zero_q;
    assign last      = emitting && (zero_q || single_bit(pending));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            zero_q  <= 1'b0;
        end else if (in_valid && in_ready) begin
            pending <= in;
            zero_q  <= (in == '0);
            state   <= EMIT;
        end else if (out_valid && out_ready) begin
            // Clearing bit 0 of an all-zero vector is harmless, so the zero beat needs no special case.
            pending <= pending & ~(REQ_W'(1) << idx);
            if (last) state <= IDLE;
        end
    end

endmodule

// File: tb/tb_encoder8_to_3_seq.sv
// Scoreboard bench: two instances (lowest-first and highest-first) share stimulus;
// each accepted vector is expanded into its expected beat list and checked as beats appear.
module tb_encoder8_to_3_seq;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
        logic       zero;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;
    logic [1:0] ir;
    logic [1:0] ov;
    logic [1:0] lst;
    logic [1:0] zr;
    logic [2:0] outv [2];
    logic       rand_mode;

    beat_t      exp_q [2][$];
    logic [7:0] vec_q [2][$];
    logic [7:0] acc   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encoder8_to_3_seq #(.LOW_FIRST(1)) dut_low (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in_vec),
        .in_ready(ir[0]), .out_valid(ov[0]), .out_ready(out_ready),
        .out(outv[0]), .last(lst[0]), .zero(zr[0])
    );

    encoder8_to_3_seq #(.LOW_FIRST(0)) dut_high (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in(in_vec),
        .in_ready(ir[1]), .out_valid(ov[1]), .out_ready(out_ready),
        .out(outv[1]), .last(lst[1]), .zero(zr[1])
    );

    task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Reference: beats are the set-bit indices in ascending order (reversed for highest-first).
    function automatic void push_vec(input int d, input logic [7:0] v);
        logic [2:0] idxs [$];
        for (int k = 0; k < 8; k++) begin
            if (v[k]) begin
                if (d == 0) idxs.push_back(3'(k));
                else        idxs.push_front(3'(k));
            end
        end
        if (idxs.size() == 0) begin
            exp_q[d].push_back(beat_t'{idx: 3'd0, last: 1'b1, zero: 1'b1});
        end else begin
            for (int i = 0; i < idxs.size(); i++)
                exp_q[d].push_back(beat_t'{idx: idxs[i], last: (i == idxs.size() - 1), zero: 1'b0});
        end
        vec_q[d].push_back(v);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                exp_q[d].delete();
                vec_q[d].delete();
                acc[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (exp_q[d].size() == 0) begin
                    chk("idle_out_valid", d, 8'(ov[d]), 8'h00);
                    chk("idle_in_ready", d, 8'(ir[d]), 8'(en));
                    chk("idle_out", d, 8'(outv[d]), 8'h00);
                    chk("idle_last", d, 8'(lst[d]), 8'h00);
                    chk("idle_zero", d, 8'(zr[d]), 8'h00);
                    if (in_valid && en) push_vec(d, in_vec);
                end else if (!en) begin
                    chk("stall_out_valid", d, 8'(ov[d]), 8'h00);
                    chk("stall_in_ready", d, 8'(ir[d]), 8'h00);
                end else begin
                    beat_t e;
                    e = exp_q[d][0];
                    chk("emit_in_ready", d, 8'(ir[d]), 8'h00);
                    chk("emit_out_valid", d, 8'(ov[d]), 8'h01);
                    chk("beat_out", d, 8'(outv[d]), 8'(e.idx));
                    chk("beat_last", d, 8'(lst[d]), 8'(e.last));
                    chk("beat_zero", d, 8'(zr[d]), 8'(e.zero));
                    if (out_ready) begin
                        logic [7:0] one;
                        one = 8'h01;
                        void'(exp_q[d].pop_front());
                        if (!e.zero) acc[d] = acc[d] | (one << outv[d]);
                        if (e.last) begin
                            chk("decoded_or", d, acc[d], vec_q[d].pop_front());
                            acc[d] = '0;
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) begin
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic send(input logic [7:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_vec   = v;
        forever begin
            @(negedge clk);
            if (ir[0]) begin
                tick();
                break;
            end
            tick();
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout vec=%0h in_ready never seen", v);
                break;
            end
        end
        in_valid = 1'b0;
        in_vec   = $urandom_range(0, 255);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
            tick();
            n++;
            if (n > 400) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout remaining=%0d/%0d expected 0", exp_q[0].size(), exp_q[1].size());
                break;
            end
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;
        rand_mode = 1'b0;
        acc[0]    = '0;
        acc[1]    = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        out_ready = 1'b1;
        send(8'b1010_0100);
        drain();
        send(8'h00);
        drain();

        out_ready = 1'b0;
        send(8'hFF);
        repeat (3) tick();
        out_ready = 1'b1;
        drain();

        send(8'b1001_0000);
        tick();
        en       = 1'b0;
        in_valid = 1'b1;
        in_vec   = 8'h3C;
        repeat (4) tick();
        en = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        drain();

        rand_mode = 1'b1;
        for (int v = 0; v < 256; v++) begin
            send(8'(v));
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain();
        rand_mode = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        tick();

        send(8'hFF);
        repeat (2) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/encoder8_to_3_seq.md
ENCODER8_TO_3_SEQ -- requirements
Module: encoder8_to_3_seq

Interface
REQ-001 SHALL have parameter LOW_FIRST, default 1, meaning 1 = emit lowest set index first and 0 = highest first.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port en  input  1  block enable; 0 stalls all handshakes.
REQ-005 SHALL have port in_valid  input  1  request vector valid.
REQ-006 SHALL have port in  input  8  request vector, bit k = request k.
REQ-007 SHALL have port in_ready  output  1  block can accept a vector.
REQ-008 SHALL have port out_valid  output  1  out/last/zero valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts current beat.
REQ-010 SHALL have port out  output  3  binary index of the current set bit.
REQ-011 SHALL have port last  output  1  current beat is the final beat for this vector.
REQ-012 SHALL have port zero  output  1  accepted vector was all-zero; out=0 is not a real index.

Function
REQ-013 SHALL implement two states, IDLE and EMIT, plus an 8-bit pending register.
REQ-014 in_ready SHALL be 1 only in IDLE with en=1; input handshake = in_valid & in_ready.
REQ-015 On input handshake, SHALL load pending<=in and enter EMIT next cycle; in is ignored at all other times.
REQ-016 First out_valid SHALL assert the cycle after the input handshake (latency 1).
REQ-017 In EMIT, out_valid SHALL equal en; out SHALL be the selected set bit of pending (lowest if LOW_FIRST=1, else highest).
REQ-018 last SHALL be 1 when pending has exactly one set bit, or when zero=1.
REQ-019 Output handshake = out_valid & out_ready: SHALL clear the emitted bit from pending; if last=1, return to IDLE.
REQ-020 out, last and zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 An all-zero vector SHALL produce exactly one beat: out=0, zero=1, last=1.
REQ-022 zero SHALL be 0 for any non-zero vector; beats per vector = popcount(in), or 1 if in=0.
REQ-023 en=0 SHALL freeze state and pending, force in_ready=0 and out_valid=0; resume unchanged when en=1.
REQ-024 No new vector SHALL be accepted in the cycle of the last output handshake (in_ready returns the following cycle).
REQ-025 out_ready asserted while out_valid=0 SHALL have no effect.

Reset
REQ-026 When rst_n=0 at a clock edge: state<=IDLE, pending<=0, zero<=0.
REQ-027 During/after reset: out_valid=0, out=0, last=0, zero=0; in_ready=en in the first cycle after rst_n rises.
REQ-028 Reset during EMIT SHALL discard remaining beats with no further out_valid.

Structure
REQ-029 Shared package SHALL hold state encoding (IDLE, EMIT) and widths (REQ_W=8, IDX_W=3).
REQ-030 Priority selection SHALL be a combinational sub-module prio_enc8 (vector in, index out, LOW_FIRST parameter); it is the inverse of decoder3_to_8.

Verification
REQ-031 Reset, en=1: in_ready=1, out_valid=0, out=0.
REQ-032 in=8'b1010_0100, out_ready=1, LOW_FIRST=1 -> beats out=2,5,7 on consecutive cycles, last=1 only on 7, zero=0.
REQ-033 in=8'h00 -> one beat out=0, zero=1, last=1; in_ready=1 two cycles after accept.
REQ-034 in=8'hFF, out_ready held 0 for 3 cycles -> out=0 stable; then out_ready=1 -> 0..7, eight beats.
REQ-035 in=8'b1001_0000, en=0 after first beat for 4 cycles -> out_valid=0 meanwhile, then out=7 with last=1; in_valid during EMIT ignored.
REQ-036 Drive all 256 vectors through decoder3_to_8-based checker: OR of decoded beats equals accepted vector; LOW_FIRST=0 order reversed; reset mid-EMIT yields no further beats.
